// File: rtl/sa2x2_ctrl_if.sv
// Host-side bundle for the sa2x2 job controller: weight config, activation stream, result stream.
// Latency: wiring only, no storage.
// Backpressure: cfg and input use ready/valid into the controller; results use ready/valid out of it.
interface sa2x2_ctrl_if #(
  parameter int DATA_W = 8
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [4*DATA_W-1:0]   cfg_w;
  logic                  in_valid;
  logic                  in_ready;
  logic [2*DATA_W-1:0]   in_x;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   out_y;
  logic                  out_last;
  logic                  busy;

  // Host side: offers config and activations, consumes results.
  modport master (
    output cfg_valid, cfg_w, in_valid, in_x, in_last, out_ready,
    input  cfg_ready, in_ready, out_valid, out_y, out_last, busy
  );

  // Controller side.
  modport slave (
    input  cfg_valid, cfg_w, in_valid, in_x, in_last, out_ready,
    output cfg_ready, in_ready, out_valid, out_y, out_last, busy
  );
endinterface

// File: rtl/sa2x2_ctrl.sv
// Job controller for the 2x2 weight-stationary systolic array: load weights, skew activations in, deskew results out.
// Latency: vector accepted in cycle c appears on out_y no earlier than cycle c+5; one vector per cycle.
// Backpressure: in_ready is a credit check (FIFO occupancy + vectors in flight < depth), so the result FIFO never overflows.
module sa2x2_ctrl #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  sa2x2_ctrl_if.slave       host,
  output logic              sa_clear,
  output logic              sa_weight_load,
  output logic [DATA_W-1:0] sa_w11,
  output logic [DATA_W-1:0] sa_w12,
  output logic [DATA_W-1:0] sa_w21,
  output logic [DATA_W-1:0] sa_w22,
  output logic [DATA_W-1:0] sa_act_in1,
  output logic [DATA_W-1:0] sa_act_in2,
  output logic [DATA_W-1:0] sa_psum_in1,
  output logic [DATA_W-1:0] sa_psum_in2,
  input  logic [DATA_W-1:0] sa_psum_out1,
  input  logic [DATA_W-1:0] sa_psum_out2
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, STREAM, DRAIN} state_t;

  state_t              state;

  // Bit i set: a vector accepted i+1 cycles ago is still travelling through the array.
  logic [3:0]          vld_sr;
  logic [3:0]          last_sr;
  logic [2:0]          inflight;
  logic [DATA_W-1:0]   x2_q;
  logic [DATA_W-1:0]   y1_q;

  logic [2*DATA_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       fifo_count;
  logic [CW:0]         used;
  logic [2*DATA_W:0]   head;

  logic                in_ready;
  logic                accept;
  logic                cfg_hs;
  logic                push;
  logic                pop;
  logic                out_valid;

  // Count vectors still inside the array pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < 4; i++) begin
      inflight = inflight + {2'b00, vld_sr[i]};
    end
  end

  assign used      = {1'b0, fifo_count} + {{(CW-2){1'b0}}, inflight};
  assign in_ready  = (state == STREAM) && (used < (CW+1)'(FIFO_DEPTH));
  assign accept    = host.in_valid && in_ready;
  assign cfg_hs    = host.cfg_valid && (state == IDLE);
  // The result of a vector is complete once it reaches the last skew stage.
  assign push      = vld_sr[3];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && host.out_ready;
  assign head      = mem[rd_ptr];

  assign host.cfg_ready = (state == IDLE);
  assign host.in_ready  = in_ready;
  assign host.out_valid = out_valid;
  assign host.out_y     = out_valid ? head[2*DATA_W-1:0] : '0;
  assign host.out_last  = out_valid ? head[2*DATA_W] : 1'b0;
  assign host.busy      = (state != IDLE) || out_valid;

  // Top-of-column partial sums are always zero: each job computes a fresh product.
  assign sa_psum_in1 = '0;
  assign sa_psum_in2 = '0;

  // Job sequencing: latch weights, one-cycle clear, one-cycle load, stream, then drain the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      sa_clear       <= 1'b0;
      sa_weight_load <= 1'b0;
      sa_w11         <= '0;
      sa_w12         <= '0;
      sa_w21         <= '0;
      sa_w22         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_hs) begin
            sa_w11   <= host.cfg_w[DATA_W-1:0];
            sa_w12   <= host.cfg_w[2*DATA_W-1:DATA_W];
            sa_w21   <= host.cfg_w[3*DATA_W-1:2*DATA_W];
            sa_w22   <= host.cfg_w[4*DATA_W-1:3*DATA_W];
            sa_clear <= 1'b1;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          sa_clear       <= 1'b0;
          sa_weight_load <= 1'b1;
          state          <= LOAD;
        end
        LOAD: begin
          sa_weight_load <= 1'b0;
          state          <= STREAM;
        end
        STREAM: begin
          if (accept && host.in_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight == '0) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Row skew on the way in, column deskew on the way out: x1 at c+1, x2 at c+2, y1 held from c+3 to pair with y2 at c+4.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr     <= '0;
      last_sr    <= '0;
      sa_act_in1 <= '0;
      sa_act_in2 <= '0;
      x2_q       <= '0;
      y1_q       <= '0;
    end else begin
      vld_sr     <= {vld_sr[2:0], accept};
      last_sr    <= {last_sr[2:0], accept && host.in_last};
      sa_act_in1 <= accept ? host.in_x[DATA_W-1:0] : '0;
      sa_act_in2 <= vld_sr[0] ? x2_q : '0;
      if (accept) begin
        x2_q <= host.in_x[2*DATA_W-1:DATA_W];
      end
      if (vld_sr[2]) begin
        y1_q <= sa_psum_out1;
      end
    end
  end

  // Result storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= {last_sr[3], sa_psum_out2, y1_q};
    end
  end

  // Result FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sa2x2_ctrl.sv
// Bench for sa2x2_ctrl: behavioural 2x2 array plus a transaction-level reference model checked every cycle.
// Latency: model predicts each result at accept cycle + 5 and the exact in_ready credit state.
// Backpressure: exercised with held, random and full-stall out_ready.
module tb_sa2x2_ctrl;
  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int INF   = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sa2x2_ctrl_if #(.DATA_W(W)) bus ();

  logic         sa_clear, sa_weight_load;
  logic [W-1:0] sa_w11, sa_w12, sa_w21, sa_w22;
  logic [W-1:0] sa_act_in1, sa_act_in2, sa_psum_in1, sa_psum_in2;
  logic [W-1:0] sa_psum_out1, sa_psum_out2;

  sa2x2_ctrl #(.DATA_W(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .host(bus),
    .sa_clear(sa_clear), .sa_weight_load(sa_weight_load),
    .sa_w11(sa_w11), .sa_w12(sa_w12), .sa_w21(sa_w21), .sa_w22(sa_w22),
    .sa_act_in1(sa_act_in1), .sa_act_in2(sa_act_in2),
    .sa_psum_in1(sa_psum_in1), .sa_psum_in2(sa_psum_in2),
    .sa_psum_out1(sa_psum_out1), .sa_psum_out2(sa_psum_out2)
  );

  // Behavioural weight-stationary array: every PE registers its activation and psum.
  logic [W-1:0] aw11 = 0, aw12 = 0, aw21 = 0, aw22 = 0;
  logic [W-1:0] p11 = 0, p12 = 0, p21 = 0, p22 = 0, a11 = 0, a21 = 0;
  always @(posedge clk) begin
    if (sa_weight_load) begin
      aw11 <= sa_w11; aw12 <= sa_w12; aw21 <= sa_w21; aw22 <= sa_w22;
    end
    if (sa_clear) begin
      p11 <= 0; p12 <= 0; p21 <= 0; p22 <= 0; a11 <= 0; a21 <= 0;
    end else begin
      p11 <= sa_psum_in1 + sa_act_in1 * aw11;
      a11 <= sa_act_in1;
      p12 <= sa_psum_in2 + a11 * aw12;
      p21 <= p11 + sa_act_in2 * aw21;
      a21 <= sa_act_in2;
      p22 <= p12 + a21 * aw22;
    end
  end
  assign sa_psum_out1 = p21;
  assign sa_psum_out2 = p22;

  typedef struct {
    logic [W-1:0] y1;
    logic [W-1:0] y2;
    logic         last;
    int           acc;
    int           pop;
  } res_t;

  res_t q[$];
  res_t log_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int idle_at = 0, stream_from = INF, clr_at = -1, load_at = -1;
  logic [W-1:0] mw11 = 0, mw12 = 0, mw21 = 0, mw22 = 0;
  bit acc_p1 = 0, acc_p2 = 0;
  logic [W-1:0] x1_p1 = 0, x2_p1 = 0, x2_p2 = 0;
  bit rand_rdy = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: compares every output each cycle, then applies the handshakes that complete at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      idle_at = 0; stream_from = INF; clr_at = -1; load_at = -1;
      mw11 = 0; mw12 = 0; mw21 = 0; mw22 = 0;
      acc_p1 = 0; acc_p2 = 0; x1_p1 = 0; x2_p1 = 0; x2_p2 = 0;
    end else begin
      bit ev, idle, acc;
      logic [W-1:0] x1, x2;
      res_t r;
      ev   = (q.size() > 0) && (q[0].acc + 5 <= cyc);
      idle = (cyc >= idle_at);
      chk("out_valid", int'(bus.out_valid), int'(ev));
      if (ev && bus.out_valid) begin
        chk("out_y", int'(bus.out_y), int'({q[0].y2, q[0].y1}));
        chk("out_last", int'(bus.out_last), int'(q[0].last));
      end
      chk("in_ready", int'(bus.in_ready), int'(cyc >= stream_from && q.size() < DEPTH));
      chk("cfg_ready", int'(bus.cfg_ready), int'(idle));
      chk("busy", int'(bus.busy), int'(!idle || q.size() > 0));
      chk("sa_clear", int'(sa_clear), int'(cyc == clr_at));
      chk("sa_weight_load", int'(sa_weight_load), int'(cyc == load_at));
      chk("sa_weights", int'({sa_w22, sa_w21, sa_w12, sa_w11}), int'({mw22, mw21, mw12, mw11}));
      chk("sa_act_in1", int'(sa_act_in1), acc_p1 ? int'(x1_p1) : 0);
      chk("sa_act_in2", int'(sa_act_in2), acc_p2 ? int'(x2_p2) : 0);
      chk("sa_psum_in", int'({sa_psum_in2, sa_psum_in1}), 0);
      chk("occupancy_bound", int'(q.size() <= DEPTH), 1);

      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        r = q.pop_front();
        r.pop = cyc;
        log_q.push_back(r);
      end
      if (bus.cfg_valid && bus.cfg_ready) begin
        {mw22, mw21, mw12, mw11} = bus.cfg_w;
        clr_at = cyc + 1; load_at = cyc + 2; stream_from = cyc + 3; idle_at = INF;
      end
      acc = bus.in_valid && bus.in_ready;
      x1 = bus.in_x[W-1:0];
      x2 = bus.in_x[2*W-1:W];
      if (acc) begin
        r.y1 = W'(x1 * mw11 + x2 * mw21);
        r.y2 = W'(x1 * mw12 + x2 * mw22);
        r.last = bus.in_last;
        r.acc = cyc;
        r.pop = -1;
        q.push_back(r);
        if (bus.in_last) begin
          stream_from = INF;
          idle_at = cyc + 6;
        end
      end
      acc_p2 = acc_p1; x2_p2 = x2_p1;
      acc_p1 = acc; x1_p1 = x1; x2_p1 = x2;
    end
    cyc++;
  end

  // Random result-side backpressure when enabled.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic cfg_job(input logic [W-1:0] w11, w12, w21, w22);
    bit done = 0;
    bus.cfg_w = {w22, w21, w12, w11};
    bus.cfg_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.cfg_ready) done = 1;
      @(posedge clk); #1;
    end
    bus.cfg_valid = 1'b0;
    if (!done) chk("cfg_timeout", 0, 1);
  endtask

  task automatic send(input logic [W-1:0] x1, x2, input bit last);
    bit done = 0;
    bus.in_x = {x2, x1};
    bus.in_last = last;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!bus.busy) done = 1;
    end
    @(posedge clk); #1;
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  int t2y1[4] = '{4, 2, 9, 19};
  int t2y2[4] = '{6, 4, 12, 28};
  int lb, idx;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

  initial begin
    bus.cfg_valid = 0; bus.cfg_w = 0; bus.in_valid = 0; bus.in_x = 0;
    bus.in_last = 0; bus.out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_cfg_ready", int'(bus.cfg_ready), 1);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;

    // Identity weights, single vector.
    lb = log_q.size();
    cfg_job(1, 0, 0, 1);
    send(3, 5, 1);
    wait_idle();
    chk("t1_count", log_q.size() - lb, 1);
    if (log_q.size() > lb) begin
      chk("t1_y", int'({log_q[lb].y2, log_q[lb].y1}), 16'h0503);
      chk("t1_last", int'(log_q[lb].last), 1);
      chk("t1_latency", log_q[lb].pop - log_q[lb].acc, 5);
    end

    // Back-to-back vectors.
    lb = log_q.size();
    cfg_job(1, 2, 3, 4);
    send(1, 1, 0); send(2, 0, 0); send(0, 3, 0); send(4, 5, 1);
    wait_idle();
    chk("t2_count", log_q.size() - lb, 4);
    if (log_q.size() >= lb + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t2_y1", int'(log_q[lb+i].y1), t2y1[i]);
        chk("t2_y2", int'(log_q[lb+i].y2), t2y2[i]);
        chk("t2_last", int'(log_q[lb+i].last), int'(i == 3));
        chk("t2_consecutive", log_q[lb+i].pop - log_q[lb].pop, i);
      end
    end

    // Modular wrap.
    lb = log_q.size();
    cfg_job(200, 0, 1, 0);
    send(2, 0, 1);
    wait_idle();
    chk("t3_count", log_q.size() - lb, 1);
    if (log_q.size() > lb) begin
      chk("t3_y1", int'(log_q[lb].y1), 144);
      chk("t3_y2", int'(log_q[lb].y2), 0);
    end

    // Full stall: only the FIFO depth worth of credits.
    lb = log_q.size();
    cfg_job(1, 2, 3, 4);
    bus.out_ready = 0;
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      bus.in_x = {8'(2 * idx), 8'(idx + 1)};
      bus.in_last = (idx == 9);
      bus.in_valid = (idx < 10);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk); #1;
    end
    chk("t4_accepted_stalled", idx, 8);
    bus.out_ready = 1;
    for (int c = 0; c < 100 && idx < 10; c++) begin
      bus.in_x = {8'(2 * idx), 8'(idx + 1)};
      bus.in_last = (idx == 9);
      bus.in_valid = 1;
      @(negedge clk);
      if (bus.in_ready) idx++;
      @(posedge clk); #1;
    end
    bus.in_valid = 0; bus.in_last = 0;
    wait_idle();
    chk("t4_count", log_q.size() - lb, 10);
    if (log_q.size() >= lb + 10) begin
      chk("t4_first", int'({log_q[lb].y2, log_q[lb].y1}), 16'h0201);
      chk("t4_tenth", int'({log_q[lb+9].y2, log_q[lb+9].y1}), {8'd92, 8'd64});
    end

    // Bubbles with random out_ready.
    lb = log_q.size();
    cfg_job(7, 250, 19, 3);
    rand_rdy = 1;
    for (int i = 0; i < 12; i++) begin
      send(8'($urandom), 8'($urandom), i == 11);
      @(posedge clk); #1;
    end
    wait_idle();
    rand_rdy = 0;
    @(posedge clk); #2 bus.out_ready = 1;
    chk("t5_count", log_q.size() - lb, 12);

    // Reset in the middle of a stream.
    lb = log_q.size();
    cfg_job(5, 6, 7, 8);
    send(1, 2, 0);
    send(3, 4, 0);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("t6_out_valid", int'(bus.out_valid), 0);
    chk("t6_in_ready", int'(bus.in_ready), 0);
    chk("t6_cfg_ready", int'(bus.cfg_ready), 1);
    chk("t6_weight_load", int'(sa_weight_load), 0);
    @(posedge clk); #1;
    cfg_job(2, 1, 1, 2);
    send(9, 10, 1);
    wait_idle();
    chk("t6_count", log_q.size() - lb, 1);
    if (log_q.size() > lb) begin
      chk("t6_y1", int'(log_q[lb].y1), 28);
      chk("t6_y2", int'(log_q[lb].y2), 29);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
